// File: rtl/bp_bht_pkg.sv
// Shared definitions for the bp_bht dynamic branch predictor.
//   - RISC-V opcode constants used by the IF-stage decoder
//   - hold-bus and instruction-address bus widths of the tinyriscv core
//   - bp_ctr_init(): reset value of a prediction counter (weakly not-taken)
//   - opc_class_e / bp_classify(): coarse opcode classification
package bp_bht_pkg;

  localparam int unsigned HOLD_FLAG_W = 3;   // Hold_Flag_Bus
  localparam int unsigned INST_ADDR_W = 32;  // InstAddrBus

  localparam logic [6:0] INST_JAL    = 7'b1101111;
  localparam logic [6:0] INST_TYPE_B = 7'b1100011;

  typedef enum logic [1:0] {
    OPC_OTHER  = 2'd0,
    OPC_JAL    = 2'd1,
    OPC_BRANCH = 2'd2
  } opc_class_e;

  // Weakly not-taken: the largest value whose MSB is still clear.
  function automatic int unsigned bp_ctr_init(input int unsigned ctr_w);
    return (32'd1 << (ctr_w - 1)) - 32'd1;
  endfunction

  function automatic opc_class_e bp_classify(input logic [6:0] opcode);
    opc_class_e cls;
    cls = OPC_OTHER;
    if (opcode == INST_JAL) begin
      cls = OPC_JAL;
    end else if (opcode == INST_TYPE_B) begin
      cls = OPC_BRANCH;
    end
    return cls;
  endfunction

endpackage

// File: rtl/bp_bht_sat_ctr.sv
// bp_sat_ctr: CTR_W-bit saturating up/down counter with asynchronous
// active-low reset to the weakly not-taken value.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous reset, active low
//   i_en   in   apply one step this cycle
//   i_inc  in   1 = count up (saturate at all-ones), 0 = count down (saturate at 0)
//   o_ctr  out  current counter value
module bp_sat_ctr
  import bp_bht_pkg::*;
#(
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_inc,
  output logic [CTR_W-1:0] o_ctr
);

  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(bp_ctr_init(CTR_W));

  logic [CTR_W-1:0] r_ctr;
  logic             w_at_max;
  logic             w_at_min;

  assign w_at_max = (r_ctr == '1);
  assign w_at_min = (r_ctr == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctr <= CTR_INIT;
    end else if (i_en) begin
      if (i_inc && !w_at_max) begin
        r_ctr <= r_ctr + 1'b1;
      end else if (!i_inc && !w_at_min) begin
        r_ctr <= r_ctr - 1'b1;
      end
    end
  end

  assign o_ctr = r_ctr;

endmodule

// File: rtl/bp_bht.sv
// bp_bht: parametrised dynamic branch predictor for the tinyriscv IF stage.
// Decodes the fetched instruction combinationally and flags a predicted-taken
// redirect (JAL always, B-type by counter MSB) plus target to pc_reg.
// Resolved conditional branches from ex train a table of saturating counters;
// resolved/mispredicted branch counts are kept as saturating statistics.
//
// Optional build macro BP_GSHARE_EN: adds an IDX_W-bit retired global history
// register XORed into the prediction index. Ports are identical in both builds.
//
// Ports:
//   clk            in   core clock
//   rst            in   asynchronous reset, active low
//   inst_i         in   fetched instruction
//   inst_addr_i    in   PC of inst_i
//   hold_flag_i    in   pipeline hold bus, non-zero = held (no redirect)
//   isbranch_o     out  predicted taken, pc_reg loads branch_addr_o
//   branch_addr_o  out  predicted target (0 for non-JAL/B-type)
//   pred_idx_o     out  table index used for this prediction
//   upd_valid_i    in   conditional branch resolved in ex (one-cycle strobe)
//   upd_idx_i      in   pred_idx carried back from ex
//   upd_taken_i    in   actual outcome
//   upd_mispred_i  in   ex detected a misprediction
//   stat_clr_i     in   synchronous clear of statistics (wins over increment)
//   stat_pred_o    out  resolved conditional branch count (saturating)
//   stat_miss_o    out  mispredict count (saturating)
module bp_bht
  import bp_bht_pkg::*;
#(
  parameter  int unsigned ENTRIES = 64,
  parameter  int unsigned CTR_W   = 2,
  parameter  int unsigned ADDR_W  = INST_ADDR_W,
  parameter  int unsigned STAT_W  = 32,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            inst_i,
  input  logic [ADDR_W-1:0]      inst_addr_i,
  input  logic [HOLD_FLAG_W-1:0] hold_flag_i,
  output logic                   isbranch_o,
  output logic [ADDR_W-1:0]      branch_addr_o,
  output logic [IDX_W-1:0]       pred_idx_o,
  input  logic                   upd_valid_i,
  input  logic [IDX_W-1:0]       upd_idx_i,
  input  logic                   upd_taken_i,
  input  logic                   upd_mispred_i,
  input  logic                   stat_clr_i,
  output logic [STAT_W-1:0]      stat_pred_o,
  output logic [STAT_W-1:0]      stat_miss_o
);

  // ---------------------------------------------------------------------------
  // Counter table: flops, one saturating counter per entry.
  // ---------------------------------------------------------------------------
  logic [CTR_W-1:0] w_ctr [ENTRIES];

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    logic w_hit;
    assign w_hit = upd_valid_i && (upd_idx_i == IDX_W'(g));

    bp_sat_ctr #(
      .CTR_W (CTR_W)
    ) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_hit),
      .i_inc (upd_taken_i),
      .o_ctr (w_ctr[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Prediction index
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] w_base_idx;
  logic [IDX_W-1:0] w_idx;

  assign w_base_idx = inst_addr_i[IDX_W+1:2];

`ifdef BP_GSHARE_EN
  // Retired history: shifted only by resolved branches, so it is
  // independent of speculative fetch.
  logic [IDX_W-1:0] r_ghr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ghr <= '0;
    end else if (upd_valid_i) begin
      r_ghr <= {r_ghr[IDX_W-2:0], upd_taken_i};
    end
  end

  assign w_idx = w_base_idx ^ r_ghr;
`else
  assign w_idx = w_base_idx;
`endif

  // ---------------------------------------------------------------------------
  // Immediates and targets (modulo 2^ADDR_W)
  // ---------------------------------------------------------------------------
  logic [20:0]       w_j_imm;
  logic [12:0]       w_b_imm;
  logic [ADDR_W-1:0] w_j_off;
  logic [ADDR_W-1:0] w_b_off;
  logic [ADDR_W-1:0] w_j_tgt;
  logic [ADDR_W-1:0] w_b_tgt;

  assign w_j_imm = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign w_b_imm = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign w_j_off = {{(ADDR_W-21){w_j_imm[20]}}, w_j_imm};
  assign w_b_off = {{(ADDR_W-13){w_b_imm[12]}}, w_b_imm};
  assign w_j_tgt = inst_addr_i + w_j_off;
  assign w_b_tgt = inst_addr_i + w_b_off;

  // ---------------------------------------------------------------------------
  // Combinational prediction. The table is read before any same-cycle update
  // lands, so a coincident update is never bypassed into the prediction.
  // ---------------------------------------------------------------------------
  logic [CTR_W-1:0] w_ctr_sel;
  opc_class_e       w_opc;

  assign w_ctr_sel = w_ctr[w_idx];
  assign w_opc     = bp_classify(inst_i[6:0]);

  always_comb begin
    isbranch_o    = 1'b0;
    branch_addr_o = '0;
    pred_idx_o    = w_idx;

    case (w_opc)
      OPC_JAL: begin
        isbranch_o    = 1'b1;
        branch_addr_o = w_j_tgt;
      end
      OPC_BRANCH: begin
        isbranch_o    = w_ctr_sel[CTR_W-1];
        branch_addr_o = w_b_tgt;
      end
      default: begin
      end
    endcase

    if (hold_flag_i != '0) begin
      isbranch_o = 1'b0;
    end

    // Outputs are combinational, so hold them at zero while reset is asserted.
    if (!rst) begin
      isbranch_o    = 1'b0;
      branch_addr_o = '0;
      pred_idx_o    = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics (saturating, clear has priority)
  // ---------------------------------------------------------------------------
  logic [STAT_W-1:0] r_stat_pred;
  logic [STAT_W-1:0] r_stat_miss;
  logic              w_inc_pred;
  logic              w_inc_miss;

  assign w_inc_pred = upd_valid_i && (r_stat_pred != '1);
  assign w_inc_miss = upd_valid_i && upd_mispred_i && (r_stat_miss != '1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_pred <= '0;
      r_stat_miss <= '0;
    end else if (stat_clr_i) begin
      r_stat_pred <= '0;
      r_stat_miss <= '0;
    end else begin
      if (w_inc_pred) begin
        r_stat_pred <= r_stat_pred + 1'b1;
      end
      if (w_inc_miss) begin
        r_stat_miss <= r_stat_miss + 1'b1;
      end
    end
  end

  assign stat_pred_o = r_stat_pred;
  assign stat_miss_o = r_stat_miss;

endmodule

// File: tb/tb_bp_bht.sv
module tb_bp_bht;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic [2:0]  hold_flag_i;
  logic        upd_valid_i;
  logic [5:0]  upd_idx_i;
  logic        upd_taken_i;
  logic        upd_mispred_i;
  logic        stat_clr_i;

  logic        isbranch_o;
  logic [31:0] branch_addr_o;
  logic [5:0]  pred_idx_o;
  logic [31:0] stat_pred_o;
  logic [31:0] stat_miss_o;

  logic        s_isbranch;
  logic [31:0] s_branch_addr;
  logic [5:0]  s_pred_idx;
  logic [3:0]  s_stat_pred;
  logic [3:0]  s_stat_miss;

  always #5 clk = ~clk;

  bp_bht u_dut (
    .clk           (clk),
    .rst           (rst),
    .inst_i        (inst_i),
    .inst_addr_i   (inst_addr_i),
    .hold_flag_i   (hold_flag_i),
    .isbranch_o    (isbranch_o),
    .branch_addr_o (branch_addr_o),
    .pred_idx_o    (pred_idx_o),
    .upd_valid_i   (upd_valid_i),
    .upd_idx_i     (upd_idx_i),
    .upd_taken_i   (upd_taken_i),
    .upd_mispred_i (upd_mispred_i),
    .stat_clr_i    (stat_clr_i),
    .stat_pred_o   (stat_pred_o),
    .stat_miss_o   (stat_miss_o)
  );

  // Narrow statistics instance so counter saturation is reachable quickly.
  bp_bht #(
    .STAT_W (4)
  ) u_dut_sat (
    .clk           (clk),
    .rst           (rst),
    .inst_i        (inst_i),
    .inst_addr_i   (inst_addr_i),
    .hold_flag_i   (hold_flag_i),
    .isbranch_o    (s_isbranch),
    .branch_addr_o (s_branch_addr),
    .pred_idx_o    (s_pred_idx),
    .upd_valid_i   (upd_valid_i),
    .upd_idx_i     (upd_idx_i),
    .upd_taken_i   (upd_taken_i),
    .upd_mispred_i (upd_mispred_i),
    .stat_clr_i    (stat_clr_i),
    .stat_pred_o   (s_stat_pred),
    .stat_miss_o   (s_stat_miss)
  );

  int total = 0;
  int bad   = 0;

  // ---- reference model ----
  int          m_ctr [64];
  longint      m_pred, m_miss, m_pred_s, m_miss_s;
  logic [5:0]  m_ghr;

  localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;
  localparam longint MAX4  = 64'd15;

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) m_ctr[i] = 1;
    m_pred = 0; m_miss = 0; m_pred_s = 0; m_miss_s = 0;
    m_ghr = '0;
  endfunction

  function automatic longint sat_inc(input longint v, input longint mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  function automatic void m_upd(input int idx, input bit taken, input bit mis);
    if (taken) m_ctr[idx] = (m_ctr[idx] >= 3) ? 3 : m_ctr[idx] + 1;
    else       m_ctr[idx] = (m_ctr[idx] <= 0) ? 0 : m_ctr[idx] - 1;
    m_pred   = sat_inc(m_pred, MAX32);
    m_pred_s = sat_inc(m_pred_s, MAX4);
    if (mis) begin
      m_miss   = sat_inc(m_miss, MAX32);
      m_miss_s = sat_inc(m_miss_s, MAX4);
    end
    m_ghr = {m_ghr[4:0], taken};
  endfunction

  function automatic logic [5:0] exp_idx(input logic [31:0] addr);
`ifdef BP_GSHARE_EN
    return addr[7:2] ^ m_ghr;
`else
    return addr[7:2];
`endif
  endfunction

  // ---- checking ----
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        br;
    logic [31:0] tgt;
    logic [5:0]  idx;
  } exp_t;

  exp_t sbq[$];

  task automatic drive_pred(input string nm, input logic [31:0] inst, input logic [31:0] addr,
                            input logic [2:0] hold, input logic br, input logic [31:0] tgt,
                            input logic [5:0] idx);
    exp_t e;
    inst_i      = inst;
    inst_addr_i = addr;
    hold_flag_i = hold;
    e.name = nm; e.br = br; e.tgt = tgt; e.idx = idx;
    sbq.push_back(e);
  endtask

  task automatic check_pred();
    exp_t e;
    @(negedge clk);
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL sbq_empty: got 0 entries want >=1");
    end else begin
      e = sbq.pop_front();
      chk({e.name, "_br"},  32'(isbranch_o),    32'(e.br));
      chk({e.name, "_tgt"}, branch_addr_o,      e.tgt);
      chk({e.name, "_idx"}, 32'(pred_idx_o),    32'(e.idx));
    end
  endtask

  // Predict a B-type at addr from the model's counter state.
  task automatic pred_b(input string nm, input logic [31:0] inst, input logic [31:0] addr,
                        input logic [2:0] hold, input logic [31:0] tgt);
    logic [5:0] ix;
    ix = exp_idx(addr);
    drive_pred(nm, inst, addr, hold, (m_ctr[ix] >= 2) && (hold == 3'b000), tgt, ix);
    check_pred();
  endtask

  task automatic upd(input int idx, input bit taken, input bit mis);
    upd_valid_i   = 1'b1;
    upd_idx_i     = 6'(idx);
    upd_taken_i   = taken;
    upd_mispred_i = mis;
    @(posedge clk); #1;
    upd_valid_i   = 1'b0;
    upd_mispred_i = 1'b0;
    m_upd(idx, taken, mis);
  endtask

  task automatic chk_stats(input string nm);
    chk({nm, "_pred"},   stat_pred_o,       m_pred[31:0]);
    chk({nm, "_miss"},   stat_miss_o,       m_miss[31:0]);
    chk({nm, "_pred_s"}, 32'(s_stat_pred),  m_pred_s[31:0]);
    chk({nm, "_miss_s"}, 32'(s_stat_miss),  m_miss_s[31:0]);
  endtask

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] addr;
    logic [2:0]  hold;
    logic        br;
    logic [31:0] tgt;
    logic [5:0]  idx;
  } vec_t;

  localparam logic [31:0] B_P8  = 32'h0000_0463;  // beq x0,x0,+8
  localparam logic [31:0] B_M4  = 32'hFE00_0EE3;  // beq x0,x0,-4
  localparam logic [31:0] JAL16 = 32'h0100_006F;  // jal x0,+16

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{"b_fwd",    B_P8,               32'h0000_0100, 3'b000, 1'b0, 32'h0000_0108, 6'h00};
    tbl[1] = '{"jal",      JAL16,              32'h0000_0200, 3'b000, 1'b1, 32'h0000_0210, 6'h00};
    tbl[2] = '{"jal_hold", JAL16,              32'h0000_0200, 3'b001, 1'b0, 32'h0000_0210, 6'h00};
    tbl[3] = '{"b_neg",    B_M4,               32'h0000_0000, 3'b000, 1'b0, 32'hFFFF_FFFC, 6'h00};
    tbl[4] = '{"jalr",     32'h0000_8067,      32'h0000_0104, 3'b000, 1'b0, 32'h0000_0000, 6'h01};
    tbl[5] = '{"addi",     32'h0010_0093,      32'h0000_01FC, 3'b000, 1'b0, 32'h0000_0000, 6'h3F};
    tbl[6] = '{"jal_wrap", JAL16,              32'hFFFF_FFF8, 3'b000, 1'b1, 32'h0000_0008, 6'h3E};
    tbl[7] = '{"jal_h4",   JAL16,              32'h0000_0204, 3'b100, 1'b0, 32'h0000_0214, 6'h01};

    rst = 1'b0;
    inst_i = '0; inst_addr_i = '0; hold_flag_i = '0;
    upd_valid_i = 1'b0; upd_idx_i = '0; upd_taken_i = 1'b0; upd_mispred_i = 1'b0;
    stat_clr_i = 1'b0;
    m_reset();

    // Outputs forced low during reset even for a JAL.
    drive_pred("in_reset", JAL16, 32'h0000_0200, 3'b000, 1'b0, 32'h0, 6'h00);
    check_pred();
    chk_stats("rst");
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive_pred(tbl[i].name, tbl[i].inst, tbl[i].addr, tbl[i].hold,
                 tbl[i].br, tbl[i].tgt, tbl[i].idx);
      check_pred();
    end

    // Train idx 0 taken twice -> predicts taken.
    @(posedge clk); #1;
    upd(0, 1, 0);
    upd(0, 1, 0);
    drive_pred("b_trained", B_P8, 32'h0000_0100, 3'b000, 1'b1, 32'h0000_0108, 6'h00);
    check_pred();
    pred_b("b_trained_hold", B_P8, 32'h0000_0100, 3'b010, 32'h0000_0108);

    // Saturation high: 5 taken then one not-taken stays taken.
    for (int i = 0; i < 5; i++) upd(0, 1, 0);
    upd(0, 0, 0);
    pred_b("sat_hi", B_P8, 32'h0000_0100, 3'b000, 32'h0000_0108);
    // Saturation low: 5 not-taken then one taken stays not-taken.
    for (int i = 0; i < 5; i++) upd(0, 0, 0);
    upd(0, 1, 0);
    pred_b("sat_lo", B_P8, 32'h0000_0100, 3'b000, 32'h0000_0108);

    // Same-cycle update and predict: prediction sees the old counter.
    @(posedge clk); #1;
    upd_valid_i = 1'b1; upd_idx_i = exp_idx(32'h0000_0100); upd_taken_i = 1'b1;
    pred_b("rbw_old", B_P8, 32'h0000_0100, 3'b000, 32'h0000_0108);
    @(posedge clk); #1;
    upd_valid_i = 1'b0;
    m_upd(int'(upd_idx_i), 1'b1, 1'b0);
    pred_b("rbw_new", B_P8, 32'h0000_0100, 3'b000, 32'h0000_0108);
    pred_b("other_idx", B_P8, 32'h0000_0104, 3'b000, 32'h0000_010C);
    chk_stats("pre_clr");

    // Clear wins over a same-cycle increment.
    stat_clr_i = 1'b1;
    upd(5, 1, 1);
    stat_clr_i = 1'b0;
    m_pred = 0; m_miss = 0; m_pred_s = 0; m_miss_s = 0;
    chk_stats("clr");

    // 10 updates, 3 mispredicts.
    for (int i = 0; i < 10; i++) upd(5, i[0], (i % 3) == 0 && i < 9);
    chk_stats("ten");
    chk("ten_pred_const", stat_pred_o, 32'd10);
    chk("ten_miss_const", stat_miss_o, 32'd3);

    // Mispredict without valid is ignored.
    upd_mispred_i = 1'b1;
    @(posedge clk); #1;
    upd_mispred_i = 1'b0;
    chk_stats("mis_novalid");

    // Push narrow instance into saturation.
    for (int i = 0; i < 15; i++) upd(6, 1, 1);
    chk_stats("sat");
    chk("sat_pred_s_const", 32'(s_stat_pred), 32'd15);

    // Reset during a pending update discards it.
    upd(2, 1, 0);
    upd(2, 1, 0);
    pred_b("pre_rst", B_P8, 32'h0000_0108, 3'b000, 32'h0000_0110);
    upd_valid_i = 1'b1; upd_idx_i = 6'd2; upd_taken_i = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    upd_valid_i = 1'b0;
    m_reset();
    rst = 1'b1;
    pred_b("post_rst", B_P8, 32'h0000_0108, 3'b000, 32'h0000_0110);
    chk_stats("post_rst");

    // History: two taken updates on idx 3, then PC 0x100.
    upd(3, 1, 0);
    upd(3, 1, 0);
`ifdef BP_GSHARE_EN
    drive_pred("ghr", B_P8, 32'h0000_0100, 3'b000, 1'b1, 32'h0000_0108, 6'h03);
`else
    drive_pred("ghr", B_P8, 32'h0000_0100, 3'b000, 1'b0, 32'h0000_0108, 6'h00);
`endif
    check_pred();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
